mem_access_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline register: takes the EX/MEM outputs (WB control, mem_read/mem_write, ALU result, store data, destination register).
- Runs a multi-cycle req/ack handshake to the data memory and stalls the pipeline until the access completes.
- Drives the MEM/WB register outputs.
- Sits between the EX/MEM register and the WB stage. The stall output freezes the PC, IF/ID, ID/EX and EX/MEM registers.

---
 rtl/mem_access_stage_if.sv | 20 ++
 rtl/mem_access_stage.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   req   : request, held high until the access completes or is aborted
//   we    : 1 = store, 0 = load
//   addr  : byte address of the access
//   wdata : store data
//   ack   : one-cycle completion strobe from memory
//   rdata : load data, valid only while ack is high
// master = MEM stage, slave = memory.
interface mem_access_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM pipeline stage. It consumes the EX/MEM register outputs, runs a
// multi-cycle req/ack access to data memory for loads and stores, and
// drives the MEM/WB register. While an access is outstanding, stall
// freezes PC, IF/ID, ID/EX and EX/MEM.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ctrl_wb_in        WB control from EX/MEM
//   ctrl_m_mem_read   load request
//   ctrl_m_mem_write  store request (wins if both are set)
//   alu_result_in     access address, or pass-through value
//   mux7_in           store data
//   mux8_in           destination register
//   dmem              data-memory bus (master side)
//   stall             combinational upstream freeze
//   ctrl_wb_out, read_data_out, alu_result_out, rd_out   MEM/WB register
//   mem_err           sticky access-timeout flag
//
// Optional build macro MEM_TIMEOUT_EN: abort a BUSY access after
// TIMEOUT_CYCLES cycles without ack. A timed-out load returns BAD_DATA,
// and mem_err is set until reset. Without the macro, BUSY waits forever
// and mem_err is constant 0.
module mem_access_stage #(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] BAD_DATA       = 32'hDEAD_BEEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 ctrl_wb_in,
   input  logic                       ctrl_m_mem_read,
   input  logic                       ctrl_m_mem_write,
   input  logic [31:0]                alu_result_in,
   input  logic [31:0]                mux7_in,
   input  logic [4:0]                 mux8_in,
   mem_access_stage_if.master         dmem,
   output logic                       stall,
   output logic [1:0]                 ctrl_wb_out,
   output logic [31:0]                read_data_out,
   output logic [31:0]                alu_result_out,
   output logic [4:0]                 rd_out,
   output logic                       mem_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   // Instruction latched at access start, replayed into MEM/WB in DONE
   logic [1:0]  wb_lat_q, wb_lat_d;
   logic [31:0] alu_lat_q, alu_lat_d;
   logic [4:0]  rd_lat_q, rd_lat_d;
   logic [31:0] rdat_lat_q, rdat_lat_d;
   // MEM/WB register
   logic [1:0]  wb_out_q, wb_out_d;
   logic [31:0] rdat_out_q, rdat_out_d;
   logic [31:0] alu_out_q, alu_out_d;
   logic [4:0]  rd_out_q, rd_out_d;
   logic        mem_err_q, mem_err_d;

   logic acc;
   logic tmo_hit;
   logic stall_raw;

   assign acc = ctrl_m_mem_read | ctrl_m_mem_write;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q counts completed BUSY cycles; the abort happens at the edge that
   // ends the TIMEOUT_CYCLES-th BUSY cycle without ack.
   assign tmo_hit = (state_q == BUSY) && !dmem.ack &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE)      cnt_d = '0;
      else if (state_q == BUSY) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_lat_d   = wb_lat_q;
      alu_lat_d  = alu_lat_q;
      rd_lat_d   = rd_lat_q;
      rdat_lat_d = rdat_lat_q;
      mem_err_d  = mem_err_q;
      // MEM/WB defaults to a bubble
      wb_out_d   = '0;
      rdat_out_d = '0;
      alu_out_d  = '0;
      rd_out_d   = '0;
      stall_raw  = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc) begin
               stall_raw = 1'b1;
               req_d     = 1'b1;
               we_d      = ctrl_m_mem_write;
               addr_d    = alu_result_in;
               wdata_d   = mux7_in;
               wb_lat_d  = ctrl_wb_in;
               alu_lat_d = alu_result_in;
               rd_lat_d  = mux8_in;
               state_d   = BUSY;
            end else begin
               wb_out_d  = ctrl_wb_in;
               alu_out_d = alu_result_in;
               rd_out_d  = mux8_in;
            end
         end
         BUSY: begin
            stall_raw = 1'b1;
            if (dmem.ack) begin
               rdat_lat_d = we_q ? 32'h0 : dmem.rdata;
               req_d      = 1'b0;
               state_d    = DONE;
            end else if (tmo_hit) begin
               rdat_lat_d = we_q ? 32'h0 : BAD_DATA;
               req_d      = 1'b0;
               mem_err_d  = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            // EX/MEM advances on this edge; the inputs still showing the
            // completed instruction are deliberately not re-examined.
            wb_out_d   = wb_lat_q;
            rdat_out_d = rdat_lat_q;
            alu_out_d  = alu_lat_q;
            rd_out_d   = rd_lat_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_lat_q   <= '0;
         alu_lat_q  <= '0;
         rd_lat_q   <= '0;
         rdat_lat_q <= '0;
         wb_out_q   <= '0;
         rdat_out_q <= '0;
         alu_out_q  <= '0;
         rd_out_q   <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_lat_q   <= wb_lat_d;
         alu_lat_q  <= alu_lat_d;
         rd_lat_q   <= rd_lat_d;
         rdat_lat_q <= rdat_lat_d;
         wb_out_q   <= wb_out_d;
         rdat_out_q <= rdat_out_d;
         alu_out_q  <= alu_out_d;
         rd_out_q   <= rd_out_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Gated by rst_n so upstream unfreezes the moment reset is asserted,
   // even if EX/MEM still presents an access.
   assign stall          = stall_raw & rst_n;
   assign dmem.req       = req_q;
   assign dmem.we        = we_q;
   assign dmem.addr      = addr_q;
   assign dmem.wdata     = wdata_q;
   assign ctrl_wb_out    = wb_out_q;
   assign read_data_out  = rdat_out_q;
   assign alu_result_out = alu_out_q;
   assign rd_out         = rd_out_q;
`ifdef MEM_TIMEOUT_EN
   assign mem_err        = mem_err_q;
`else
   assign mem_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Scoreboard bench for mem_access_stage: each instruction pushes its
// expected MEM/WB contents when driven; the entry is popped and compared
// when the stage releases the instruction. A behavioural memory answers
// requests after a programmable number of BUSY cycles and checks that the
// request stays stable while outstanding.
module tb_mem_access_stage;
   localparam logic [31:0] BAD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  ctrl_wb_in = '0;
   logic        mem_rd = 1'b0, mem_wr = 1'b0;
   logic [31:0] alu_in = '0, wdata_in = '0;
   logic [4:0]  rd_in = '0;
   logic        stall, mem_err;
   logic [1:0]  ctrl_wb_out;
   logic [31:0] read_data_out, alu_result_out;
   logic [4:0]  rd_out;

   logic        ack_m = 1'b0, spur = 1'b0;
   logic [31:0] rdata_m = '0;

   always #5 clk = ~clk;

   mem_access_stage_if bus ();
   assign bus.ack   = ack_m | spur;
   assign bus.rdata = rdata_m;

   mem_access_stage #(.TIMEOUT_CYCLES(4), .BAD_DATA(BAD)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ctrl_wb_in       (ctrl_wb_in),
      .ctrl_m_mem_read  (mem_rd),
      .ctrl_m_mem_write (mem_wr),
      .alu_result_in    (alu_in),
      .mux7_in          (wdata_in),
      .mux8_in          (rd_in),
      .dmem             (bus),
      .stall            (stall),
      .ctrl_wb_out      (ctrl_wb_out),
      .read_data_out    (read_data_out),
      .alu_result_out   (alu_result_out),
      .rd_out           (rd_out),
      .mem_err          (mem_err)
   );

   typedef struct {
      logic [1:0]  wb;
      logic [31:0] rdat;
      logic [31:0] alu;
      logic [4:0]  rd;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0, n_fail = 0;

   // memory model configuration, set per instruction
   int          mem_ack_after = 0;   // ack in this BUSY cycle; 0 = never
   logic [31:0] mem_rdata = '0;
   logic        exp_we = 1'b0;
   logic [31:0] exp_addr = '0, exp_wdata = '0;
   int          req_cycles = 0;
   bit          acked = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory: acts on the falling edge so ack/rdata are settled at the next
   // rising edge. Stray rdata outside ack must be ignored by the DUT.
   always @(negedge clk) begin
      ack_m   = 1'b0;
      rdata_m = 32'h5A5A_5A5A;
      if (bus.req && !acked) begin
         req_cycles++;
         chk("dmem_we",    {31'h0, bus.we}, {31'h0, exp_we});
         chk("dmem_addr",  bus.addr, exp_addr);
         chk("dmem_wdata", bus.wdata, exp_wdata);
         if (mem_ack_after != 0 && req_cycles == mem_ack_after) begin
            ack_m   = 1'b1;
            rdata_m = mem_rdata;
            acked   = 1;
         end
      end else if (!bus.req) begin
         acked = 0;
      end
   end

   task automatic issue(input logic [1:0] wb, input logic r, input logic w,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input int ack_after,
                        input logic [31:0] rdat, input int exp_stall);
      exp_t e;
      int   ns;
      bit   done;
      mem_ack_after = ack_after;
      mem_rdata     = rdat;
      exp_we        = w;
      exp_addr      = alu;
      exp_wdata     = wd;
      req_cycles    = 0;
      ctrl_wb_in = wb; mem_rd = r; mem_wr = w;
      alu_in = alu; wdata_in = wd; rd_in = rd;
      e.wb  = wb;
      e.alu = alu;
      e.rd  = rd;
      if (r && !w) e.rdat = (ack_after == 0) ? BAD : rdat;
      else         e.rdat = 32'h0;
      exp_q.push_back(e);
      ns = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         if (!stall) done = 1;
         else begin
            ns++;
            if (ns >= 2) begin
               chk("bubble_wb", {30'h0, ctrl_wb_out}, 32'h0);
               chk("bubble_rd", {27'h0, rd_out}, 32'h0);
            end
            if (ns > 300) begin
               chk("stall_bound", ns, 300);
               done = 1;
            end
         end
      end
      chk("stall_cycles", ns, exp_stall);
      if (r | w) chk("req_cycles", req_cycles, exp_stall - 1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("wb_out",   {30'h0, ctrl_wb_out}, {30'h0, e.wb});
      chk("rdat_out", read_data_out, e.rdat);
      chk("alu_out",  alu_result_out, e.alu);
      chk("rd_out",   {27'h0, rd_out}, {27'h0, e.rd});
      chk("req_gap",  {31'h0, bus.req}, 32'h0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req"},   {31'h0, bus.req}, 32'h0);
      chk({tag, "_we"},    {31'h0, bus.we}, 32'h0);
      chk({tag, "_addr"},  bus.addr, 32'h0);
      chk({tag, "_wdata"}, bus.wdata, 32'h0);
      chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
      chk({tag, "_wb"},    {30'h0, ctrl_wb_out}, 32'h0);
      chk({tag, "_rdat"},  read_data_out, 32'h0);
      chk({tag, "_alu"},   alu_result_out, 32'h0);
      chk({tag, "_rd"},    {27'h0, rd_out}, 32'h0);
      chk({tag, "_err"},   {31'h0, mem_err}, 32'h0);
   endtask

   initial begin
      #12;
      reset_checks("rst");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;

      // pass-through, zero-wait load, wait-state store, read+write together
      issue(2'b10, 0, 0, 32'h0000_0010, 32'h0, 5'd5, 0, 32'h0, 0);
      issue(2'b11, 1, 0, 32'h0000_0040, 32'h0, 5'd7, 1, 32'hCAFE_0001, 2);
      issue(2'b01, 0, 1, 32'h0000_0080, 32'h1234_5678, 5'd3, 3, 32'h0BAD_0BAD, 4);
      issue(2'b11, 1, 1, 32'h0000_00C0, 32'hA5A5_A5A5, 5'd9, 2, 32'h7777_7777, 3);
      issue(2'b01, 1, 0, 32'h0000_0044, 32'h0, 5'd10, 1, 32'h1357_9BDF, 2);

      // spurious ack while idle must be ignored
      spur = 1'b1;
      issue(2'b10, 0, 0, 32'h0000_0055, 32'h0, 5'd12, 0, 32'h0, 0);
      spur = 1'b0;

      for (int i = 0; i < 8; i++) begin
         int          kind, d;
         logic [1:0]  wb;
         logic [31:0] a, wd, rdv;
         logic [4:0]  rd;
         kind = $urandom_range(0, 2);
         d    = $urandom_range(1, 4);
         wb   = 2'($urandom);
         a    = $urandom;
         wd   = $urandom;
         rdv  = $urandom;
         rd   = 5'($urandom);
         case (kind)
            0:       issue(wb, 0, 0, a, wd, rd, 0, rdv, 0);
            1:       issue(wb, 1, 0, a, wd, rd, d, rdv, d + 1);
            default: issue(wb, 0, 1, a, wd, rd, d, rdv, d + 1);
         endcase
      end

      // asynchronous reset in the middle of an unanswered load
      mem_ack_after = 0; req_cycles = 0;
      exp_we = 1'b0; exp_addr = 32'h0000_0100; exp_wdata = 32'h0;
      ctrl_wb_in = 2'b11; mem_rd = 1'b1; mem_wr = 1'b0;
      alu_in = 32'h0000_0100; wdata_in = 32'h0; rd_in = 5'd4;
      repeat (3) @(negedge clk);
      chk("busy_req", {31'h0, bus.req}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      reset_checks("mid_rst");
      ctrl_wb_in = 2'b00; mem_rd = 1'b0; alu_in = 32'h0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
      issue(2'b01, 0, 0, 32'h0000_0123, 32'h0, 5'd6, 0, 32'h0, 0);

`ifdef MEM_TIMEOUT_EN
      issue(2'b11, 1, 0, 32'h0000_0200, 32'h0, 5'd8, 0, 32'h0, 5);
      chk("tmo_err", {31'h0, mem_err}, 32'h1);
      issue(2'b10, 0, 0, 32'h0000_0011, 32'h0, 5'd2, 0, 32'h0, 0);
      chk("tmo_err_sticky", {31'h0, mem_err}, 32'h1);
`else
      begin
         int ns;
         mem_ack_after = 0; req_cycles = 0;
         exp_we = 1'b0; exp_addr = 32'h0000_0200; exp_wdata = 32'h0;
         ctrl_wb_in = 2'b11; mem_rd = 1'b1; mem_wr = 1'b0;
         alu_in = 32'h0000_0200; wdata_in = 32'h0; rd_in = 5'd8;
         ns = 0;
         repeat (120) begin
            @(negedge clk);
            if (stall) ns++;
         end
         chk("stuck_stall", ns, 120);
         chk("stuck_req", {31'h0, bus.req}, 32'h1);
         chk("stuck_err", {31'h0, mem_err}, 32'h0);
         rst_n = 1'b0;
         ctrl_wb_in = 2'b00; mem_rd = 1'b0; alu_in = 32'h0; rd_in = 5'd0;
         @(negedge clk) rst_n = 1'b1;
         @(posedge clk) #1;
         issue(2'b10, 0, 0, 32'h0000_0011, 32'h0, 5'd2, 0, 32'h0, 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
